parallel_accumulator_rr: RTL and testbench
==========================================

// Module: parallel_accumulator_rr
// PURPOSE
//  Parametrised successor of the four-processor accumulator: NUM_PROC adder lanes share one operand pool
//  through an internal round-robin arbiter, on a single clock. A valid/ready load port replaces the
//  "load != 0" convention, so zero is a legal operand. The pool is reduced to a single sum, which is
//  presented on result with a one-cycle result_valid pulse.
// PARAMETERS
//  WIDTH     32  operand/result width in bits
//  DEPTH     16  operand pool entries; must be >= 2
//  NUM_PROC   4  adder lanes / arbiter requesters, 1..8
//  ADD_LAT    2  cycles from fetch grant to the lane raising its writeback request; must be >= 1
// PORTS
//  proc_clk      in   1      sole clock, rising edge
//  reset         in   1      synchronous, active-low
//  load_valid    in   1      load_data is valid this cycle
//  load_data     in   WIDTH  operand to push into the pool
//  load_last     in   1      final operand of the set; sampled only when load_valid=1
//  load_ready    out  1      pool accepts a push this cycle
//  result        out  WIDTH  final sum, held until the next DONE
//  result_valid  out  1      one-cycle pulse when result updates
//  busy          out  1      high in LOAD, REDUCE and DONE
//  overflow      out  1      sticky: a lane add carried out of WIDTH bits
// BEHAVIOUR
//  - Reset (reset=0 at an edge): state=IDLE, pool count=0, all lanes idle, RR pointer=0, result=0,
//    result_valid=0, busy=0, overflow=0, load_ready=1. A reset mid-operation aborts in-flight adds; nothing is written back.
//  - FSM states: IDLE -> LOAD -> REDUCE -> DONE -> IDLE.
//    IDLE:   the first accepted push clears overflow and moves to LOAD, or to REDUCE if load_last=1.
//    LOAD:   a push with load_last=1 moves to REDUCE.
//    REDUCE: when count==1 and no lane is busy, move to DONE.
//    DONE:   for exactly one cycle, result <= pool head, result_valid=1, count <= 0; then IDLE.
//  - load_ready = (IDLE or LOAD) and count < DEPTH. A push while load_ready=0 is ignored; no state changes.
//  - Pool: circular FIFO with head/tail pointers that wrap modulo DEPTH, plus a count.
//  - Lanes: each lane is IDLE, ADD or WB.
//    * A fetch request needs lane IDLE, state REDUCE and count >= 2.
//    * A fetch grant pops head and head+1 in the same cycle (count -= 2) and the lane enters ADD.
//    * After ADD_LAT cycles the lane enters WB and raises a writeback request.
//    * A writeback grant pushes the sum to the tail (count += 1) and the lane returns to IDLE.
//      Writeback never blocks, because every fetch frees two entries.
//  - Arbiter: exactly one grant per cycle across all fetch and writeback requests.
//    * Search starts at the RR pointer and goes upward modulo NUM_PROC.
//    * After a grant to lane i, pointer = (i+1) mod NUM_PROC. With no grant, the pointer holds.
//    * Among lanes with count >= 2, the fetch eligibility check uses the count value before this cycle's update.
//  - Arithmetic: unsigned; sum = (a+b) mod 2^WIDTH. Any carry-out sets overflow.
//  - Single operand (load_last on the first push): REDUCE sees count==1 and no lanes busy, so result
//    appears 2 cycles after the accepting edge.
//  - load_valid while in REDUCE/DONE: load_ready=0, so the push is ignored.
// CONFIGURATION
//  - ACC_SATURATE_EN defined: a lane sum that carries out is clamped to {WIDTH{1'b1}}, and overflow is still set.
//  - ACC_SATURATE_EN undefined: sums wrap modulo 2^WIDTH. Ports are the same in both builds.
// TESTING
//  1. Push 1,2,3,4 (load_last on 4), defaults -> one result_valid pulse, result=10, overflow=0, busy falls after DONE.
//  2. Push 32'h0 then 32'h0 with last -> result=0 with result_valid pulse (zero is a legal operand).
//  3. Push 32'hFFFFFFFF, 32'h2 with last -> result=32'h1, overflow=1. With ACC_SATURATE_EN: result=32'hFFFFFFFF, overflow=1.
//  4. Push 1..16 (DEPTH=16), then hold load_valid with 99 -> load_ready=0, 99 ignored, result=136.
//  5. Drive reset=0 for one edge mid-REDUCE -> next cycle busy=0, load_ready=1, result=0, overflow=0. Then push 5,7(last) -> result=12.
//  6. Push 8 operands, NUM_PROC=4 -> first four fetch grants go to lanes 0,1,2,3 in order, one per cycle.
//     No lane is granted twice while another lane has a pending request.

Source files
------------

// File: rtl/parallel_accumulator_rr.sv
// Shared-pool accumulator: NUM_PROC adder lanes reduce a loaded operand set to one sum via a round-robin arbiter.
// Build option ACC_SATURATE_EN: a lane sum that carries out is clamped to all-ones instead of wrapping.
module parallel_accumulator_rr #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int NUM_PROC = 4,
  parameter int ADD_LAT  = 2
) (
  input  logic             proc_clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic             overflow
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
  localparam int TW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_REDUCE, S_DONE} state_t;
  typedef enum logic [1:0] {L_IDLE, L_ADD, L_WB} lane_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_pool [DEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  lane_t                 r_lane_st  [NUM_PROC];
  logic [TW-1:0]         r_lane_tmr [NUM_PROC];
  logic [WIDTH-1:0]      r_lane_sum [NUM_PROC];
  logic [NUM_PROC-1:0]   r_lane_cy;
  logic [LW-1:0]         r_ptr;
  logic [WIDTH-1:0]      r_result;
  logic                  r_result_valid;
  logic                  r_overflow;

  logic                  w_push_ld;
  logic                  w_fetch_ok;
  logic                  w_any_busy;
  logic [NUM_PROC-1:0]   w_req;
  logic                  w_gnt_valid;
  logic [LW-1:0]         w_gnt_idx;
  logic                  w_gnt_fetch;
  logic                  w_gnt_wb;
  logic [PW-1:0]         w_head_nx;
  logic [WIDTH:0]        w_add;
  logic [WIDTH-1:0]      w_lane_res;
  logic                  w_wr_en;
  logic [WIDTH-1:0]      w_wr_data;

  function automatic logic [PW-1:0] f_wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign load_ready   = ((r_state == S_IDLE) || (r_state == S_LOAD)) && (r_count < CW'(DEPTH));
  assign w_push_ld    = load_valid && load_ready;
  assign w_fetch_ok   = (r_state == S_REDUCE) && (r_count >= CW'(2));
  assign busy         = (r_state != S_IDLE);
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign overflow     = r_overflow;

  always_comb begin
    w_any_busy = 1'b0;
    for (int i = 0; i < NUM_PROC; i++) begin
      w_req[i]   = ((r_lane_st[i] == L_IDLE) && w_fetch_ok) || (r_lane_st[i] == L_WB);
      w_any_busy = w_any_busy || (r_lane_st[i] != L_IDLE);
    end
  end

  // Round-robin search: first requester at or above the pointer, wrapping modulo NUM_PROC.
  always_comb begin
    int v_idx;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    w_gnt_valid = 1'b0;
    w_gnt_idx   = '0;
    v_idx       = 0;
    for (int k = 0; k < NUM_PROC; k++) begin
      v_idx = (int'(r_ptr) + k) % NUM_PROC;
      if (!w_gnt_valid && w_req[v_idx]) begin
        w_gnt_valid = 1'b1;
        w_gnt_idx   = LW'(v_idx);
      end
    end
  end

  assign w_gnt_fetch = w_gnt_valid && (r_lane_st[w_gnt_idx] == L_IDLE);
  assign w_gnt_wb    = w_gnt_valid && !w_gnt_fetch;

  assign w_head_nx = f_wrap_inc(r_head);
  assign w_add     = {1'b0, r_pool[r_head]} + {1'b0, r_pool[w_head_nx]};
`ifdef ACC_SATURATE_EN
  assign w_lane_res = w_add[WIDTH] ? '1 : w_add[WIDTH-1:0];
`else
  assign w_lane_res = w_add[WIDTH-1:0];
`endif

  assign w_wr_en   = reset && (w_push_ld || w_gnt_wb);
  assign w_wr_data = w_push_ld ? load_data : r_lane_sum[w_gnt_idx];

  // NOTE: pool storage has no reset; count/head/tail alone define which entries are live.
  always_ff @(posedge proc_clk) begin
    if (w_wr_en) r_pool[r_tail] <= w_wr_data;
  end

  always_ff @(posedge proc_clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_ptr          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
      r_lane_cy      <= '0;
      for (int i = 0; i < NUM_PROC; i++) begin
        r_lane_st[i]  <= L_IDLE;
        r_lane_tmr[i] <= '0;
        r_lane_sum[i] <= '0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE:   if (w_push_ld) begin
                    r_overflow <= 1'b0;
                    r_state    <= load_last ? S_REDUCE : S_LOAD;
                  end
        S_LOAD:   if (w_push_ld && load_last) r_state <= S_REDUCE;
        S_REDUCE: if ((r_count == CW'(1)) && !w_any_busy) r_state <= S_DONE;
        S_DONE:   begin
                    r_result       <= r_pool[r_head];
                    r_result_valid <= 1'b1;
                    r_state        <= S_IDLE;
                  end
        default:  r_state <= S_IDLE;
      endcase

      if (r_state == S_DONE) begin
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
      end else if (w_push_ld) begin
        r_tail  <= f_wrap_inc(r_tail);
        r_count <= r_count + 1'b1;
      end else if (w_gnt_fetch) begin
        r_head  <= f_wrap_inc(w_head_nx);
        r_count <= r_count - CW'(2);
      end else if (w_gnt_wb) begin
        r_tail     <= f_wrap_inc(r_tail);
        r_count    <= r_count + 1'b1;
        r_overflow <= r_overflow | r_lane_cy[w_gnt_idx];
      end

      if (w_gnt_valid) r_ptr <= (int'(w_gnt_idx) == NUM_PROC - 1) ? '0 : w_gnt_idx + 1'b1;

      for (int i = 0; i < NUM_PROC; i++) begin
        case (r_lane_st[i])
          L_IDLE: if (w_gnt_fetch && (int'(w_gnt_idx) == i)) begin
                    r_lane_st[i]  <= L_ADD;
                    r_lane_tmr[i] <= TW'(ADD_LAT - 1);
                    r_lane_sum[i] <= w_lane_res;
                    r_lane_cy[i]  <= w_add[WIDTH];
                  end
          L_ADD:  if (r_lane_tmr[i] == '0) r_lane_st[i] <= L_WB;
                  else r_lane_tmr[i] <= r_lane_tmr[i] - 1'b1;
          L_WB:   if (w_gnt_wb && (int'(w_gnt_idx) == i)) r_lane_st[i] <= L_IDLE;
          default: r_lane_st[i] <= L_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_parallel_accumulator_rr.sv
// Directed bench for parallel_accumulator_rr (default parameters); each task drives one scenario and checks inline.
module tb_parallel_accumulator_rr;
  logic        proc_clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic [31:0] result;
  logic        result_valid;
  logic        busy;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  parallel_accumulator_rr dut (
    .proc_clk(proc_clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .result(result), .result_valid(result_valid),
    .busy(busy), .overflow(overflow)
  );

  always #5 proc_clk = ~proc_clk;

  // All tasks start and end at a falling edge; inputs change there, outputs are sampled there.
  task automatic apply_reset();
    reset = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    @(posedge proc_clk); @(negedge proc_clk);
    reset = 1'b1;
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    int guard = 0;
    while (!load_ready && guard < 50) begin @(negedge proc_clk); guard++; end
    if (!load_ready) begin
      checks++; failures++;
      $display("FAIL push_ready: load_ready=%0b required 1 within 50 cycles", load_ready);
    end
    load_valid = 1'b1; load_data = d; load_last = l;
    @(posedge proc_clk); @(negedge proc_clk);
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic wait_result(input int budget, output logic [31:0] res, output int pulses,
                             output logic busy_at, output logic busy_before);
    logic prev_busy;
    pulses = 0; res = '0; busy_at = 1'b1; busy_before = 1'b0; prev_busy = busy;
    for (int c = 0; c < budget; c++) begin
      if (result_valid) begin
        pulses++;
        if (pulses == 1) begin res = result; busy_at = busy; busy_before = prev_busy; end
      end
      prev_busy = busy;
      @(negedge proc_clk);
    end
  endtask

  task automatic expect_sum(input string name, input logic [31:0] exp, input int budget);
    logic [31:0] res; int pulses; logic b_at, b_before;
    wait_result(budget, res, pulses, b_at, b_before);
    checks++;
    if (pulses !== 1) begin failures++; $display("FAIL %s_pulses: got %0d required 1", name, pulses); end
    checks++;
    if (res !== exp) begin failures++; $display("FAIL %s_result: got %0h required %0h", name, res, exp); end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b required 0", busy); end
    checks++; if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b required 1", load_ready); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result: got %0h required 0", result); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_rv: got %0b required 0", result_valid); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %0b required 0", overflow); end
  endtask

  task automatic test_basic();
    logic [31:0] res; int pulses; logic b_at, b_before;
    push(32'd1, 1'b0); push(32'd2, 1'b0); push(32'd3, 1'b0); push(32'd4, 1'b1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_run: got %0b required 1", busy); end
    wait_result(60, res, pulses, b_at, b_before);
    checks++; if (pulses !== 1) begin failures++; $display("FAIL basic_pulses: got %0d required 1", pulses); end
    checks++; if (res !== 32'd10) begin failures++; $display("FAIL basic_result: got %0h required a", res); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %0b required 0", overflow); end
    checks++; if (b_before !== 1'b1 || b_at !== 1'b0) begin
      failures++; $display("FAIL basic_busy_fall: before=%0b at_pulse=%0b required 1/0", b_before, b_at);
    end
  endtask

  task automatic test_zero();
    push(32'h0, 1'b0); push(32'h0, 1'b1);
    expect_sum("zero", 32'h0, 40);
  endtask

  task automatic test_single();
    push(32'd42, 1'b1);
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL single_rv_c0: got %0b required 0", result_valid); end
    @(negedge proc_clk);
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL single_rv_c1: got %0b required 0", result_valid); end
    @(negedge proc_clk);
    checks++; if (result_valid !== 1'b1 || result !== 32'd42) begin
      failures++; $display("FAIL single_rv_c2: rv=%0b result=%0h required 1/2a", result_valid, result);
    end
    @(negedge proc_clk);
    checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL single_pulse_len: got %0b required 0", result_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp;
`ifdef ACC_SATURATE_EN
    exp = 32'hFFFF_FFFF;
`else
    exp = 32'h0000_0001;
`endif
    push(32'hFFFF_FFFF, 1'b0); push(32'h2, 1'b1);
    expect_sum("ovf", exp, 40);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %0b required 1", overflow); end
  endtask

  task automatic test_full_stall();
    logic [31:0] res; int pulses; logic b_at, b_before;
    for (int i = 1; i <= 16; i++) push(32'(i), 1'b0);
    checks++; if (load_ready !== 1'b0) begin failures++; $display("FAIL full_ready: got %0b required 0", load_ready); end
    load_valid = 1'b1; load_data = 32'd99; load_last = 1'b1;
    repeat (3) @(negedge proc_clk);
    load_valid = 1'b0; load_last = 1'b0;
    wait_result(40, res, pulses, b_at, b_before);
    checks++; if (pulses !== 0) begin failures++; $display("FAIL full_ignored: pulses=%0d required 0", pulses); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy: got %0b required 1", busy); end
    apply_reset();
  endtask

  task automatic test_full_pool();
    for (int i = 1; i <= 16; i++) push(32'(i), (i == 16));
    load_valid = 1'b1; load_data = 32'd99; load_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (load_ready !== 1'b0 || result_valid !== 1'b0) begin
        failures++; $display("FAIL pool_hold_%0d: ready=%0b rv=%0b required 0/0", c, load_ready, result_valid);
      end
      @(negedge proc_clk);
    end
    load_valid = 1'b0; load_last = 1'b0;
    expect_sum("pool", 32'd136, 150);
  endtask

  task automatic test_mid_reset();
    int guard = 0;
    push(32'hFFFF_FFFF, 1'b0); push(32'hFFFF_FFFF, 1'b0); push(32'd3, 1'b0); push(32'd4, 1'b1);
    while (!overflow && guard < 60) begin @(negedge proc_clk); guard++; end
    checks++; if (overflow !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL mid_pre: ovf=%0b busy=%0b required 1/1", overflow, busy);
    end
    reset = 1'b0;
    @(posedge proc_clk); @(negedge proc_clk);
    reset = 1'b1;
    checks++; if (busy !== 1'b0 || load_ready !== 1'b1) begin
      failures++; $display("FAIL mid_ctrl: busy=%0b ready=%0b required 0/1", busy, load_ready);
    end
    checks++; if (result !== 32'h0 || overflow !== 1'b0) begin
      failures++; $display("FAIL mid_regs: result=%0h ovf=%0b required 0/0", result, overflow);
    end
    push(32'd5, 1'b0); push(32'd7, 1'b1);
    expect_sum("mid", 32'd12, 40);
  endtask

  task automatic test_grant_order();
    int n = 0;
    int idx_q [4];
    int cyc_q [4];
    apply_reset();
    for (int i = 1; i <= 8; i++) push(32'(i), (i == 8));
    for (int c = 0; c < 40 && n < 4; c++) begin
      if (dut.w_gnt_fetch) begin idx_q[n] = int'(dut.w_gnt_idx); cyc_q[n] = c; n++; end
      @(negedge proc_clk);
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL grant_count: got %0d required 4", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (idx_q[i] !== i || cyc_q[i] !== cyc_q[0] + i) begin
        failures++; $display("FAIL grant_%0d: lane=%0d cycle_offset=%0d required lane %0d offset %0d",
                             i, idx_q[i], cyc_q[i] - cyc_q[0], i, i);
      end
    end
    expect_sum("grant", 32'd36, 80);
  endtask

  initial begin
    @(negedge proc_clk);
    test_reset();
    test_basic();
    test_zero();
    test_single();
    test_overflow();
    test_full_stall();
    test_full_pool();
    test_mid_reset();
    test_grant_order();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
